// File: rtl/temppp_pkg.sv
// Shared types and helpers for the temppp Booth multiplier: FSM states,
// Booth operation codes and the step-count rule for radix-2 / radix-4 operation.
package temppp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        NOP,
        ADD1,
        SUB1,
        ADD2,
        SUB2
    } booth_op_t;

    function automatic int step_count(input int width, input bit radix4);
        return radix4 ? (width / 2) : width;
    endfunction

endpackage

// File: rtl/temppp_booth_recode.sv
// Combinational Booth recoder: maps the {Q[1],Q[0],Q-1} window to an operation
// and produces the matching signed addend (0, +-M, +-2M) at accumulator width.
module temppp_booth_recode
    import temppp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [2:0]    window,
    input  logic [AW-1:0] mcand,
    output logic [AW-1:0] addend
);

    booth_op_t            op;
    logic signed [AW-1:0] m_s;
    logic signed [AW-1:0] m2_s;

    assign m_s  = mcand;
    assign m2_s = m_s <<< 1;

    // A radix-2 caller feeds {Q[0],Q[0],Q-1}; the radix-4 table then collapses
    // to the radix-2 rule because the 011/100 windows cannot occur.
    always_comb begin
        op = NOP;
        case (window)
            3'b001, 3'b010: op = ADD1;
            3'b011:         op = ADD2;
            3'b100:         op = SUB2;
            3'b101, 3'b110: op = SUB1;
            default:        op = NOP;
        endcase
    end

    always_comb begin
        addend = '0;
        case (op)
            ADD1:    addend = m_s;
            SUB1:    addend = -m_s;
            ADD2:    addend = m2_s;
            SUB2:    addend = -m2_s;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/temppp_booth.sv
// Sequential signed Booth multiplier, one recoded step per clock.
// Define TEMPPP_BOOTH_RADIX4_EN for radix-4 recoding (WIDTH/2 steps instead of WIDTH).
module temppp_booth
    import temppp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

`ifdef TEMPPP_BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif
    localparam int AW    = WIDTH + 1 + int'(RADIX4);
    localparam int SH    = 1 + int'(RADIX4);
    localparam int STEPS = step_count(WIDTH, RADIX4);
    localparam int CW    = $clog2(STEPS + 1);

    if (WIDTH < 2) begin : g_chk_width
        $error("temppp_booth: WIDTH must be at least 2");
    end
    if (RADIX4 && (WIDTH % 2 != 0)) begin : g_chk_even
        $error("temppp_booth: radix-4 mode requires an even WIDTH");
    end

    state_t                      state, state_nxt;
    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        mcand;
    logic [WIDTH-1:0]            qreg;
    logic                        q_m1;
    logic [CW-1:0]               count;
    logic [2:0]                  window;
    logic [AW-1:0]               addend;
    logic signed [AW-1:0]        sum;
    logic signed [AW+WIDTH:0]    full;
    logic signed [AW+WIDTH:0]    shifted;

    assign window  = RADIX4 ? {qreg[1], qreg[0], q_m1} : {qreg[0], qreg[0], q_m1};
    assign sum     = acc + $signed(addend);
    assign full    = {sum, qreg, q_m1};
    assign shifted = full >>> SH;
    assign busy    = (state == RUN);

    temppp_booth_recode #(
        .AW(AW)
    ) u_recode (
        .window (window),
        .mcand  (mcand),
        .addend (addend)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            qreg    <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
                        qreg  <= multiplier;
                        q_m1  <= 1'b0;
                        acc   <= '0;
                        count <= CW'(STEPS);
                    end
                end
                RUN: begin
                    acc   <= shifted[AW+WIDTH -: AW];
                    qreg  <= shifted[WIDTH:1];
                    q_m1  <= shifted[0];
                    count <= count - 1'b1;
                end
                FINISH: begin
                    // After the final shift {A,Q} holds the full product; the
                    // spare accumulator sign bits are redundant here.
                    product <= {acc[WIDTH-1:0], qreg};
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temppp_booth.sv
// Self-checking bench for temppp_booth: vector table, abort/handshake sequences
// and random operands, with a queue-based scoreboard checked on every done pulse.
module tb_temppp_booth;

    localparam int W = 8;
`ifdef TEMPPP_BOOTH_RADIX4_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif
    localparam int LAT = STEPS + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [W-1:0]       multiplicand;
    logic [W-1:0]       multiplier;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     product;

    temppp_booth #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] m;
        logic signed [W-1:0] q;
        longint              exp;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint exp_q[$];
    longint held = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint prod_val();
        logic signed [2*W-1:0] p;
        p = product;
        return longint'(p);
    endfunction

    // Scoreboard: pop on every done pulse, otherwise product must hold.
    always @(negedge clk) begin
        longint e;
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", prod_val(), e);
                    held = e;
                end
            end else begin
                check("product_hold", prod_val(), held);
            end
        end
    end

    task automatic issue(input logic signed [W-1:0] m, input logic signed [W-1:0] q,
                         input longint e);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        forever begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (lat > 4 * LAT) begin
                check("done_timeout", lat, LAT);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   lat, bc;
        logic seen;
        logic signed [W-1:0] rm, rq;

        tbl[0] = '{m:  8'sd5,    q:  8'sd3,    exp:  15};
        tbl[1] = '{m: -8'sd7,    q:  8'sd6,    exp: -42};
        tbl[2] = '{m:  8'sd7,    q: -8'sd6,    exp: -42};
        tbl[3] = '{m: -8'sd7,    q: -8'sd6,    exp:  42};
        tbl[4] = '{m:  8'sd0,    q: -8'sd128,  exp:  0};
        tbl[5] = '{m: -8'sd128,  q: -8'sd128,  exp:  16384};
        tbl[6] = '{m: -8'sd128,  q:  8'sd127,  exp: -16256};
        tbl[7] = '{m:  8'sd127,  q:  8'sd127,  exp:  16129};

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", prod_val(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Abort mid-run: outputs clear at once and no done ever follows.
        issue(8'sd5, 8'sd3, 15);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", prod_val(), 0);
        exp_q.delete();
        held = 0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("no_done_after_abort", seen, 0);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].m, tbl[i].q, tbl[i].exp);
            wait_done(lat, bc);
            check("latency", lat, LAT);
            check("busy_cycles", bc, STEPS);
        end

        // A second start during the run is dropped, not queued.
        issue(8'sd9, -8'sd11, -99);
        @(posedge clk);
        @(negedge clk);
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("ignored_start_idle", busy, 0);
        end

        // Random operands; a zero gap gives start in the done cycle.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            rm = W'($urandom);
            rq = W'($urandom);
            issue(rm, rq, longint'(rm) * longint'(rq));
            wait_done(lat, bc);
            if (i < 20) check("rand_latency", lat, LAT);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/temppp_booth.md
Name: temppp_booth

Overview:
- Sequential signed multiplier using Booth's algorithm (radix-2 by default).
- Accepts two WIDTH-bit two's-complement operands on a start pulse and iterates one Booth step per clock.
- Presents a 2*WIDTH-bit signed product with a one-cycle done pulse.
- Standalone arithmetic leaf for datapaths that trade latency for area.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2 (even when the radix-4 option is enabled).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- multiplicand  in  WIDTH  signed operand M, captured at accepted start
- multiplier  in  WIDTH  signed operand Q, captured at accepted start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when product is valid
- product  out  2*WIDTH  signed result, held until the next accepted start

Behaviour:
- Reset (async, immediate): busy=0, done=0, product=0, internal registers cleared, FSM=IDLE.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, FINISH.
  - IDLE→RUN on a clock edge with start=1.
  - RUN→FINISH when the step counter reaches its last step.
  - FINISH→IDLE unconditionally.
- On accept:
  - Latch M sign-extended to WIDTH+1 bits.
  - Set Q=multiplier, Q-1=0, accumulator A=0 (WIDTH+1 bits), count=WIDTH.
  - busy goes high the same edge.
- RUN, each cycle, on {Q[0],Q-1}:
  - 01: A=A+M
  - 10: A=A−M
  - 00/11: no change
  - Then arithmetic shift right of {A,Q,Q-1} by one, count−1.
- After WIDTH steps, the product is the low 2*WIDTH bits of {A,Q}.
  - The WIDTH+1-bit accumulator guarantees correctness for M=−2^(WIDTH−1).
- Latency: done=1 and product updated exactly WIDTH+1 edges after the accepting edge. busy is high for WIDTH cycles and low in the done cycle.
- start while busy or in FINISH is ignored, with no queuing.
  - start in the cycle after done is accepted normally.
- product holds its value across IDLE; it is overwritten only in a FINISH cycle.
- Operand inputs may change freely after the accepting edge.
- Full range is supported with no overflow:
  - For WIDTH=8, (−128)×(−128)=16384 (0x4000).
  - For WIDTH=8, (−128)×127=−16256 (0xC080).

Optional Feature:
- Macro TEMPPP_BOOTH_RADIX4_EN.
- Defined:
  - Radix-4 modified Booth recoding on {Q[1],Q[0],Q-1}, selecting 0, ±M, or ±2M.
  - Accumulator widened to WIDTH+2 bits; arithmetic shift by 2 per step.
  - WIDTH/2 steps; done arrives WIDTH/2+1 edges after accept.
  - WIDTH must be even; compile-time check.
- Undefined: radix-2 behaviour as above.
- Port list and results are identical in both modes; only latency differs.

Decomposition:
- Shared package temppp_pkg holds:
  - FSM state enum (IDLE, RUN, FINISH)
  - Booth-op encoding enum (NOP, ADD1, SUB1, ADD2, SUB2)
  - function computing step count from WIDTH and radix
- Natural sub-module: temppp_booth_recode.
  - Combinational; maps the Booth bit window to the op enum.
  - Produces the selected signed addend (0/±M/±2M).
- The top level holds the FSM, registers and shifter.

Test Plan:
- Reset: assert rst mid-run (after 3 steps of 5×3) → busy=0, done=0, product=0 immediately; no later done pulse.
- Basic, WIDTH=8: M=5, Q=3 → done exactly 9 edges after accept (radix-4: 5), product=15, busy high for 8 cycles.
- Signs: (−7)×6 → −42 (0xFFD6); 7×(−6) → −42; (−7)×(−6) → 42; 0×(−128) → 0.
- Extremes: (−128)×(−128) → 0x4000; (−128)×127 → 0xC080; 127×127 → 16129 (0x3F01).
- Handshake: pulse start again 2 cycles into a run with different operands → ignored, first result unchanged. Start asserted the cycle after done → accepted, back-to-back results correct.
- Random: 1000 random signed operand pairs with random start gaps → product equals the reference signed multiply every time, and product stays stable between done pulses.
